// File: rtl/march_c.sv
// March C memory-BIST controller for a 2**AW x DW single-port SRAM.
// Issues one op per clock and flags any read mismatch (sticky).
module march_c #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic [AW-1:0] addr_out,
  output logic          w_en_out,
  output logic          rst_done,
  output logic          fail
);

  typedef enum logic [3:0] {
    IDLE, E0, E1, E2, E3, E4, E5, E6, DONE
  } st_e;

  localparam logic [DW-1:0] D0 = '0;
  localparam logic [DW-1:0] D1 = '1;

  st_e           state_q;
  logic          ph_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dat_q;
  logic          wen_q;
  logic          done_q;
  logic          fail_q;

  assign dat_out  = dat_q;
  assign addr_out = addr_q;
  assign w_en_out = wen_q;
  assign rst_done = done_q;
  assign fail     = fail_q;

  function automatic logic is_down(input st_e s);
    return (s == E4) || (s == E5);
  endfunction

  function automatic logic two_op(input st_e s);
    return (s == E1) || (s == E2) || (s == E4) || (s == E5);
  endfunction

  function automatic st_e nxt(input st_e s);
    st_e n;
    n = DONE;
    unique case (s)
      E0:      n = E1;
      E1:      n = E2;
      E2:      n = E3;
      E3:      n = E4;
      E4:      n = E5;
      E5:      n = E6;
      default: n = DONE;
    endcase
    return n;
  endfunction

  // Reads are always the first op of an element; r1 only in E2/E5.
  logic [DW-1:0] exp_rd;
  logic [DW-1:0] wr2;
  logic [AW-1:0] last_a;
  logic          at_end;

  assign exp_rd = ((state_q == E2) || (state_q == E5)) ? D1 : D0;
  assign wr2    = ((state_q == E1) || (state_q == E4)) ? D1 : D0;
  assign last_a = is_down(state_q) ? '0 : '1;
  assign at_end = (addr_q == last_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (en_in) begin
            state_q <= E0;
            ph_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= D0;
            wen_q   <= 1'b1;
            fail_q  <= 1'b0;
          end
        end
        DONE: begin
          if (!en_in) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          if (!en_in) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            if (!wen_q && (dat_in != exp_rd))
              fail_q <= 1'b1;
            if (two_op(state_q) && !ph_q) begin
              ph_q  <= 1'b1;
              wen_q <= 1'b1;
              dat_q <= wr2;
            end else if (at_end) begin
              ph_q  <= 1'b0;
              wen_q <= 1'b0;
              dat_q <= '0;
              if (state_q == E6) begin
                state_q <= DONE;
                addr_q  <= '0;
                done_q  <= 1'b1;
              end else begin
                state_q <= nxt(state_q);
                addr_q  <= is_down(nxt(state_q)) ? '1 : '0;
              end
            end else begin
              ph_q   <= 1'b0;
              wen_q  <= (state_q == E0);
              dat_q  <= '0;
              addr_q <= is_down(state_q) ? addr_q - 1'b1
                                         : addr_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_c.sv
// Bench for march_c: SRAM model, op scoreboard, checkpoint table.
module tb_march_c;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_in = 1'b0;
  logic [3:0] dat_in;
  logic [3:0] dat_out;
  logic [7:0] addr_out;
  logic       w_en_out;
  logic       rst_done;
  logic       fail;

  int checks = 0;
  int errors = 0;
  bit stuck = 1'b0;
  logic [3:0] mem [256];

  always #5 clk = ~clk;

  march_c dut (
    .clk(clk), .rst(rst), .en_in(en_in), .dat_in(dat_in),
    .dat_out(dat_out), .addr_out(addr_out), .w_en_out(w_en_out),
    .rst_done(rst_done), .fail(fail)
  );

  always @(posedge clk) if (w_en_out) mem[addr_out] <= dat_out;

  always_comb begin
    dat_in = mem[addr_out];
    if (stuck && addr_out == 8'h5A) dat_in[0] = 1'b1;
  end

  typedef struct {
    logic [7:0] a;
    logic       w;
    logic [3:0] d;
  } op_t;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic       w;
    logic [3:0] d;
  } vec_t;

  op_t  q[$];
  vec_t tbl[14];

  // Element table: direction and up to two ops (write flag, value).
  task automatic build_ops();
    bit       dn [7] = '{0, 0, 0, 0, 1, 1, 0};
    int       no [7] = '{1, 2, 2, 1, 2, 2, 1};
    bit       w0 [7] = '{1, 0, 0, 0, 0, 0, 0};
    bit [3:0] v0 [7] = '{0, 0, 15, 0, 0, 15, 0};
    bit [3:0] v1 [7] = '{0, 15, 0, 0, 15, 0, 0};
    op_t o;
    q.delete();
    for (int e = 0; e < 7; e++)
      for (int i = 0; i < 256; i++) begin
        o.a = dn[e] ? 8'(255 - i) : 8'(i);
        o.w = w0[e];
        o.d = v0[e];
        q.push_back(o);
        if (no[e] == 2) begin
          o.w = 1'b1;
          o.d = v1[e];
          q.push_back(o);
        end
      end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic run_ops(input int n, input bit stk);
    op_t e;
    bit  ef;
    bit  bad;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: cycle %0d", k);
        return;
      end
      e  = q.pop_front();
      ef = stk && (k >= 437);
      bad = (addr_out != e.a) || (w_en_out != e.w) ||
            (e.w && dat_out != e.d) || rst_done || (fail != ef);
      if (bad) begin
        errors++;
        $display("FAIL op%0d: got a=%h w=%b d=%h dn=%b f=%b, required a=%h w=%b d=%h dn=0 f=%b",
                 k, addr_out, w_en_out, dat_out, rst_done, fail,
                 e.a, e.w, e.d, ef);
      end
      foreach (tbl[i])
        if (tbl[i].cyc == k) begin
          chk($sformatf("tbl%0d_addr", k), addr_out, tbl[i].a);
          chk($sformatf("tbl%0d_wen", k), w_en_out, tbl[i].w);
          if (tbl[i].w)
            chk($sformatf("tbl%0d_dat", k), dat_out, tbl[i].d);
        end
    end
  endtask

  task automatic start();
    @(negedge clk);
    en_in = 1'b1;
    build_ops();
  endtask

  initial begin
    tbl[0]  = '{0,    8'h00, 1'b1, 4'h0};
    tbl[1]  = '{255,  8'hFF, 1'b1, 4'h0};
    tbl[2]  = '{256,  8'h00, 1'b0, 4'h0};
    tbl[3]  = '{257,  8'h00, 1'b1, 4'hF};
    tbl[4]  = '{767,  8'hFF, 1'b1, 4'hF};
    tbl[5]  = '{768,  8'h00, 1'b0, 4'h0};
    tbl[6]  = '{769,  8'h00, 1'b1, 4'h0};
    tbl[7]  = '{1280, 8'h00, 1'b0, 4'h0};
    tbl[8]  = '{1535, 8'hFF, 1'b0, 4'h0};
    tbl[9]  = '{1536, 8'hFF, 1'b0, 4'h0};
    tbl[10] = '{1537, 8'hFF, 1'b1, 4'hF};
    tbl[11] = '{2047, 8'h00, 1'b1, 4'hF};
    tbl[12] = '{2048, 8'hFF, 1'b0, 4'h0};
    tbl[13] = '{2815, 8'hFF, 1'b0, 4'h0};
    foreach (mem[i]) mem[i] = 4'h5;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr_out, 0);
    chk("rst_wen", w_en_out, 0);
    chk("rst_done", rst_done, 0);
    chk("rst_fail", fail, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean run
    start();
    run_ops(2816, 1'b0);
    @(posedge clk);
    #1;
    chk("done1", rst_done, 1);
    chk("done1_fail", fail, 0);
    chk("done1_wen", w_en_out, 0);
    chk("done1_addr", addr_out, 0);
    @(negedge clk);
    en_in = 1'b0;
    @(posedge clk);
    #1;
    chk("idle1_done", rst_done, 0);

    // Stuck-at bit0 of 5A
    stuck = 1'b1;
    start();
    run_ops(2816, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("done2", rst_done, 1);
      chk("done2_fail", fail, 1);
    end
    @(negedge clk);
    en_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rel_done", rst_done, 0);
      chk("rel_fail", fail, 1);
    end
    stuck = 1'b0;

    // Restart clears fail; abort inside E2
    start();
    run_ops(800, 1'b0);
    @(negedge clk);
    en_in = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_wen", w_en_out, 0);
      chk("abort_addr", addr_out, 0);
      chk("abort_done", rst_done, 0);
    end

    // Restart after abort, then async reset mid-run
    start();
    run_ops(300, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_addr", addr_out, 0);
    chk("arst_wen", w_en_out, 0);
    chk("arst_dat", dat_out, 0);
    chk("arst_done", rst_done, 0);
    chk("arst_fail", fail, 0);
    en_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_wen", w_en_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
